// File: rtl/line_buffer_7x7.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_7x7
//  Description : Streaming line buffer feeding a 7x7 window stage. Six line
//                memories of COLS entries hold the previous six image rows;
//                each accepted pixel emits one vertically aligned 7-tap column.
//                Columns are qualified only once six complete rows of the
//                current frame are stored.
//  Ports       : clk          - rising-edge clock
//                rst          - asynchronous active-low reset
//                data_i       - input pixel, raster order
//                done_i       - data_i valid this cycle
//                S1_o..S7_o   - column taps, S1_o = row r-6 .. S7_o = row r
//                done_o       - taps hold a valid column
//                frame_done_o - pulse with the column of a frame's last pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_7x7 #(
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       done_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic [7:0] S4_o,
    output logic [7:0] S5_o,
    output logic [7:0] S6_o,
    output logic [7:0] S7_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = 1 << CW;

    localparam logic [CW-1:0] C_COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] C_ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] C_ROW_VALID = RW'(6);

    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic [6:0][7:0]   tap_q, tap_d;
    logic              done_q, done_d;
    logic              frame_done_q, frame_done_d;

    // Line memories: index 5 holds row r-1, index 0 holds row r-6.
    logic [7:0]        line_q [6][DEPTH];
    logic [5:0][7:0]   line_rd;
    logic [5:0][7:0]   line_wr_d;

    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        tap_d        = tap_q;
        done_d       = 1'b0;
        frame_done_d = 1'b0;
        line_rd      = '0;
        line_wr_d    = '0;

        for (int k = 0; k < 6; k++) begin
            line_rd[k] = line_q[k][col_cnt_q];
        end

        // Vertical shift at the current column; reads see pre-write contents.
        line_wr_d[5] = data_i;
        for (int k = 0; k < 5; k++) begin
            line_wr_d[k] = line_rd[k+1];
        end

        if (done_i) begin
            tap_d[6] = data_i;
            for (int k = 0; k < 6; k++) begin
                tap_d[k] = line_rd[k];
            end

            // Rows 0..5 of the frame only fill memories; stale data from a
            // previous frame or before reset is never qualified.
            done_d       = (row_cnt_q >= C_ROW_VALID);
            frame_done_d = (row_cnt_q == C_ROW_LAST) && (col_cnt_q == C_COL_LAST);

            if (col_cnt_q == C_COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == C_ROW_LAST) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            tap_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            tap_q        <= tap_d;
            done_q       <= done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Memories carry no reset; the row gate above hides their contents.
    for (genvar k = 0; k < 6; k++) begin : g_line
        always_ff @(posedge clk) begin
            if (done_i) begin
                line_q[k][col_cnt_q] <= line_wr_d[k];
            end
        end
    end

    assign S1_o         = tap_q[0];
    assign S2_o         = tap_q[1];
    assign S3_o         = tap_q[2];
    assign S4_o         = tap_q[3];
    assign S5_o         = tap_q[4];
    assign S6_o         = tap_q[5];
    assign S7_o         = tap_q[6];
    assign done_o       = done_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_7x7.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_buffer_7x7
//  Description : Directed self-checking bench for line_buffer_7x7, with a
//                7x7 instance and a 10x8 instance driven from ramp frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer_7x7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [7:0]      da, db;
    logic            va, vb;
    logic [6:0][7:0] sa, sb;
    logic            doa, dob, fda, fdb;

    line_buffer_7x7 #(.COLS(7), .ROWS(7)) u_dut_a (
        .clk(clk), .rst(rst_n), .data_i(da), .done_i(va),
        .S1_o(sa[0]), .S2_o(sa[1]), .S3_o(sa[2]), .S4_o(sa[3]),
        .S5_o(sa[4]), .S6_o(sa[5]), .S7_o(sa[6]),
        .done_o(doa), .frame_done_o(fda)
    );

    line_buffer_7x7 #(.COLS(10), .ROWS(8)) u_dut_b (
        .clk(clk), .rst(rst_n), .data_i(db), .done_i(vb),
        .S1_o(sb[0]), .S2_o(sb[1]), .S3_o(sb[2]), .S4_o(sb[3]),
        .S5_o(sb[4]), .S6_o(sb[5]), .S7_o(sb[6]),
        .done_o(dob), .frame_done_o(fdb)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;

    // Expected taps of the last accepted pixel, for hold checks in bubbles.
    logic [6:0][7:0] last_exp;
    logic            last_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get(input int sel, output logic [6:0][7:0] s, output logic d, output logic f);
        if (sel == 0) begin
            s = sa; d = doa; f = fda;
        end else begin
            s = sb; d = dob; f = fdb;
        end
    endtask

    task automatic check_zero(input string tag);
        logic [6:0][7:0] s;
        logic d, f;
        for (int sel = 0; sel < 2; sel++) begin
            get(sel, s, d, f);
            check($sformatf("%s_s%0d", tag, sel), 32'(s[6:4]), 32'd0);
            check($sformatf("%s_t%0d", tag, sel), 32'(s[3:0]), 32'd0);
            check($sformatf("%s_done%0d", tag, sel), 32'(d), 32'd0);
            check($sformatf("%s_fd%0d", tag, sel), 32'(f), 32'd0);
        end
    endtask

    // Accept one pixel (r,c) of a ramp frame and check the emitted column.
    task automatic pix(input int sel, input int r, input int c, input int rows,
                       input int cols, input logic [7:0] base);
        logic [7:0]      v;
        logic [6:0][7:0] s;
        logic            d, f;
        v = base + 8'(r * 16 + c);
        if (sel == 0) begin da = v; va = 1'b1; end
        else          begin db = v; vb = 1'b1; end
        @(posedge clk); #1;
        get(sel, s, d, f);
        for (int j = 0; j < 7; j++) begin
            last_exp[j] = base + 8'((r - 6 + j) * 16 + c);
        end
        last_valid = (r >= 6);
        check($sformatf("d%0d_r%0dc%0d_done", sel, r, c), 32'(d), 32'(last_valid));
        check($sformatf("d%0d_r%0dc%0d_fd", sel, r, c), 32'(f),
              32'((r == rows - 1) && (c == cols - 1)));
        check($sformatf("d%0d_r%0dc%0d_S7", sel, r, c), 32'(s[6]), 32'(v));
        if (d) n_valid++;
        if (last_valid) begin
            for (int j = 0; j < 6; j++) begin
                check($sformatf("d%0d_r%0dc%0d_S%0d", sel, r, c, j + 1),
                      32'(s[j]), 32'(last_exp[j]));
            end
        end
    endtask

    task automatic bubble(input int sel);
        logic [6:0][7:0] s;
        logic            d, f;
        if (sel == 0) begin va = 1'b0; da = 8'($urandom); end
        else          begin vb = 1'b0; db = 8'($urandom); end
        @(posedge clk); #1;
        get(sel, s, d, f);
        check("bubble_done", 32'(d), 32'd0);
        check("bubble_fd", 32'(f), 32'd0);
        check("bubble_S7_hold", 32'(s[6]), 32'(last_exp[6]));
        if (last_valid) check("bubble_S1_hold", 32'(s[0]), 32'(last_exp[0]));
    endtask

    task automatic frame(input int sel, input int rows, input int cols,
                         input logic [7:0] base, input bit bubbles, input int npix);
        int k;
        k = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (k < npix) begin
                    if (bubbles && (k % 3 == 2)) bubble(sel);
                    pix(sel, r, c, rows, cols, base);
                end
                k++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        last_exp = '0; last_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");

        // Reset held: inputs wiggle, outputs must stay zero.
        for (int i = 0; i < 8; i++) begin
            va = i[0]; vb = ~i[0]; da = 8'($urandom); db = 8'($urandom);
            @(posedge clk); #1;
            check_zero($sformatf("rst_hold%0d", i));
        end
        va = 1'b0; vb = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Full frame, continuous.
        n_valid = 0;
        frame(0, 7, 7, 8'h00, 1'b0, 49);
        check("frame1_valid_cnt", 32'(n_valid), 32'd7);

        // Same frame with a bubble every third cycle.
        n_valid = 0;
        frame(0, 7, 7, 8'h00, 1'b1, 49);
        check("bubble_valid_cnt", 32'(n_valid), 32'd7);

        // Back-to-back frames with distinct data.
        frame(0, 7, 7, 8'h00, 1'b0, 49);
        n_valid = 0;
        frame(0, 7, 7, 8'h80, 1'b0, 49);
        check("b2b_valid_cnt", 32'(n_valid), 32'd7);

        // Reset mid-frame at pixel 45, then a fresh frame.
        frame(0, 7, 7, 8'h00, 1'b0, 45);
        @(negedge clk);
        rst_n = 1'b0; va = 1'b0;
        #1 check_zero("rst_mid");
        @(posedge clk); #1 check_zero("rst_mid_hold");
        @(negedge clk) rst_n = 1'b1;
        n_valid = 0;
        frame(0, 7, 7, 8'h10, 1'b0, 49);
        check("rst_mid_valid_cnt", 32'(n_valid), 32'd7);
        va = 1'b0;

        // Larger geometry: 10 columns x 8 rows.
        n_valid = 0;
        frame(1, 8, 10, 8'h00, 1'b0, 80);
        check("sweep_valid_cnt", 32'(n_valid), 32'd20);
        vb = 1'b0;
        @(posedge clk); #1;
        check("sweep_idle_done", 32'(dob), 32'd0);
        check("sweep_idle_fd", 32'(fdb), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
